// File: rtl/ctrl_ramdrv_pkg.sv
// ctrl_ramdrv_pkg: shared opcodes and default widths for the RAM-driver header blocks.
package ctrl_ramdrv_pkg;
    localparam logic [1:0] CMD_NOP      = 2'b00;
    localparam logic [1:0] CMD_LOAD_CFG = 2'b01;
    localparam logic [1:0] CMD_INC      = 2'b10;
    localparam logic [1:0] CMD_CLEAR    = 2'b11;
    localparam int DEF_DATA_OFFSET_WIDTH  = 10;
    localparam int DEF_VECTOR_INDEX_WIDTH = 4;
    localparam int DEF_ADDR_WIDTH         = 12;
    localparam int DEF_STEP_WIDTH         = 4;
endpackage

// File: rtl/ctrl_ramdrv_modadd.sv
// ctrl_ramdrv_modadd: (a + b) mod len for a, b < len via one compare-subtract.
module ctrl_ramdrv_modadd #(
    parameter int W = 10
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] len,
    output logic [W-1:0] y
);
    logic [W:0] sum;
    logic [W:0] red;
    assign sum = {1'b0, a} + {1'b0, b};
    assign red = sum - {1'b0, len};
    assign y   = (sum >= {1'b0, len}) ? red[W-1:0] : sum[W-1:0];
endmodule

// File: rtl/ctrl_ramdrv_header_mc.sv
// ctrl_ramdrv_header_mc: per-channel circular-buffer head manager with a registered
// tap-address read port (read-before-write against same-cycle commands).
module ctrl_ramdrv_header_mc
    import ctrl_ramdrv_pkg::*;
#(
    parameter int DATA_OFFSET_WIDTH  = DEF_DATA_OFFSET_WIDTH,
    parameter int VECTOR_INDEX_WIDTH = DEF_VECTOR_INDEX_WIDTH,
    parameter int ADDR_WIDTH         = DEF_ADDR_WIDTH,
    parameter int STEP_WIDTH         = DEF_STEP_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cmd_valid,
    input  logic [1:0]                    cmd_op,
    input  logic [VECTOR_INDEX_WIDTH-1:0] cmd_index,
    input  logic [ADDR_WIDTH-1:0]         cfg_base,
    input  logic [DATA_OFFSET_WIDTH-1:0]  cfg_length,
    input  logic [STEP_WIDTH-1:0]         inc_step,
    input  logic                          rd_en,
    input  logic [VECTOR_INDEX_WIDTH-1:0] rd_index,
    input  logic [DATA_OFFSET_WIDTH-1:0]  rd_offset,
    output logic                          rd_valid,
    output logic [DATA_OFFSET_WIDTH-1:0]  rd_head,
    output logic [ADDR_WIDTH-1:0]         rd_addr,
    output logic                          err
);
    localparam int NCH = 1 << VECTOR_INDEX_WIDTH;
    logic [ADDR_WIDTH-1:0]        base_q [NCH];
    logic [DATA_OFFSET_WIDTH-1:0] len_q  [NCH];
    logic [DATA_OFFSET_WIDTH-1:0] head_q [NCH];
    logic [DATA_OFFSET_WIDTH-1:0] inc_b, inc_len, inc_sum;
    logic [DATA_OFFSET_WIDTH-1:0] rd_len, rd_off, rd_sum;
    logic cmd_act, inc_ok, rd_ok, cmd_err, rd_err;
    assign cmd_act = cmd_valid && cmd_op != CMD_NOP;
    assign inc_b   = DATA_OFFSET_WIDTH'(inc_step);
    assign inc_len = len_q[cmd_index];
    assign inc_ok  = inc_len != '0 && inc_b < inc_len;
    assign cmd_err = cmd_act && cmd_op == CMD_INC && !inc_ok;
    assign rd_len  = len_q[rd_index];
    assign rd_ok   = rd_len != '0 && rd_offset < rd_len;
    // An illegal tap falls back to offset 0 so the address still points at the head.
    assign rd_off  = rd_ok ? rd_offset : '0;
    assign rd_err  = rd_en && !rd_ok;
    ctrl_ramdrv_modadd #(.W(DATA_OFFSET_WIDTH)) u_inc (
        .a(head_q[cmd_index]), .b(inc_b), .len(inc_len), .y(inc_sum)
    );
    ctrl_ramdrv_modadd #(.W(DATA_OFFSET_WIDTH)) u_rd (
        .a(head_q[rd_index]), .b(rd_off), .len(rd_len), .y(rd_sum)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                base_q[i] <= '0;
                len_q[i]  <= '0;
                head_q[i] <= '0;
            end
            rd_valid <= 1'b0;
            rd_head  <= '0;
            rd_addr  <= '0;
            err      <= 1'b0;
        end else begin
            if (cmd_act && cmd_op == CMD_LOAD_CFG) begin
                base_q[cmd_index] <= cfg_base;
                len_q[cmd_index]  <= cfg_length;
                head_q[cmd_index] <= '0;
            end
            if (cmd_act && cmd_op == CMD_CLEAR) head_q[cmd_index] <= '0;
            if (cmd_act && cmd_op == CMD_INC && inc_ok) head_q[cmd_index] <= inc_sum;
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_head <= head_q[rd_index];
                rd_addr <= base_q[rd_index] + ADDR_WIDTH'(rd_sum);
            end
            err <= cmd_err | rd_err;
        end
    end
`ifdef DEBUG
    logic [8*8-1:0] dbg_op;
    always_ff @(posedge clk) begin
        dbg_op <= !cmd_valid ? "IDLE" : cmd_op == CMD_LOAD_CFG ? "LOAD_CFG" :
                  cmd_op == CMD_INC ? "INC" : cmd_op == CMD_CLEAR ? "CLEAR" : "NOP";
    end
`endif
endmodule

// File: tb/tb_ctrl_ramdrv_header_mc.sv
// tb_ctrl_ramdrv_header_mc: directed plus random stimulus against a modulo-arithmetic
// reference model, checked through an expected-response queue.
module tb_ctrl_ramdrv_header_mc;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic [1:0]  cmd_op = 2'b00;
    logic [3:0]  cmd_index = '0;
    logic [11:0] cfg_base = '0;
    logic [9:0]  cfg_length = '0;
    logic [3:0]  inc_step = '0;
    logic        rd_en = 1'b0;
    logic [3:0]  rd_index = '0;
    logic [9:0]  rd_offset = '0;
    logic        rd_valid;
    logic [9:0]  rd_head;
    logic [11:0] rd_addr;
    logic        err;

    ctrl_ramdrv_header_mc dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
        .cmd_index(cmd_index), .cfg_base(cfg_base), .cfg_length(cfg_length),
        .inc_step(inc_step), .rd_en(rd_en), .rd_index(rd_index), .rd_offset(rd_offset),
        .rd_valid(rd_valid), .rd_head(rd_head), .rd_addr(rd_addr), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int v;
        int h;
        int a;
        int e;
    } exp_t;
    exp_t q[$];
    exp_t got;
    int m_base[16], m_len[16], m_head[16];
    int last_h = 0, last_a = 0;
    int n_cmp = 0, n_bad = 0;

    function automatic void cmp(string name, int act, int expv);
        n_cmp++;
        if (act != expv) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     name, act, act, expv, expv, $time);
        end
    endfunction

    task automatic cyc(bit r, bit cv, int op, int ci, int cb, int cl, int st,
                       bit re, int ri, int ro);
        exp_t x;
        bit rok;
        int o;
        @(negedge clk);
        rst = r; cmd_valid = cv; cmd_op = 2'(op); cmd_index = 4'(ci);
        cfg_base = 12'(cb); cfg_length = 10'(cl); inc_step = 4'(st);
        rd_en = re; rd_index = 4'(ri); rd_offset = 10'(ro);
        if (r) begin
            foreach (m_len[i]) begin m_base[i] = 0; m_len[i] = 0; m_head[i] = 0; end
            last_h = 0; last_a = 0;
            x = '{0, 0, 0, 0};
        end else begin
            rok = m_len[ri] != 0 && ro < m_len[ri];
            o = rok ? ro : 0;
            if (re) begin
                last_h = m_head[ri];
                last_a = m_len[ri] == 0 ? m_base[ri] : (m_base[ri] + (m_head[ri] + o) % m_len[ri]) % 4096;
            end
            x.v = re; x.h = last_h; x.a = last_a;
            x.e = ((cv && op == 2 && !(m_len[ci] != 0 && st < m_len[ci])) || (re && !rok)) ? 1 : 0;
            if (cv && op == 1) begin m_base[ci] = cb; m_len[ci] = cl; m_head[ci] = 0; end
            if (cv && op == 3) m_head[ci] = 0;
            if (cv && op == 2 && m_len[ci] != 0 && st < m_len[ci]) m_head[ci] = (m_head[ci] + st) % m_len[ci];
        end
        q.push_back(x);
    endtask

    task automatic inc(int ch, int st, bit re = 0, int ri = 0, int ro = 0);
        cyc(0, 1, 2, ch, 0, 0, st, re, ri, ro);
    endtask

    task automatic rd(int ch, int ro);
        cyc(0, 0, 0, 0, 0, 0, 0, 1, ch, ro);
    endtask

    task automatic after_edge();
        @(posedge clk);
        #2;
    endtask

    always @(posedge clk) begin
        #1;
        if (q.size() == 0) begin
            if (rd_valid === 1'b1) cmp("unexpected_rd_valid", 1, 0);
        end else begin
            got = q.pop_front();
            cmp("rd_valid", int'(rd_valid), got.v);
            cmp("err", int'(err), got.e);
            cmp("rd_head", int'(rd_head), got.h);
            cmp("rd_addr", int'(rd_addr), got.a);
        end
    end

    initial begin
        cyc(0, 1, 1, 1, 'h055, 6, 0, 0, 0, 0);
        inc(1, 3);
        cyc(1, 1, 2, 1, 0, 0, 1, 1, 1, 0);
        cyc(1, 1, 2, 1, 0, 0, 1, 1, 1, 0);
        after_edge();
        cmp("reset_rd_valid", int'(rd_valid), 0);
        cmp("reset_rd_addr", int'(rd_addr), 0);
        for (int c = 0; c < 16; c++) rd(c, 0);
        cyc(0, 1, 1, 3, 'h100, 5, 0, 0, 0, 0);
        inc(3, 2); inc(3, 2, 1, 3, 0); inc(3, 2, 1, 3, 0);
        rd(3, 0);
        after_edge();
        cmp("wrap_head", int'(rd_head), 1);
        cmp("wrap_addr", int'(rd_addr), 'h101);
        inc(3, 2); inc(3, 1);
        rd(3, 3);
        after_edge();
        cmp("tap_valid", int'(rd_valid), 1);
        cmp("tap_head", int'(rd_head), 4);
        cmp("tap_addr", int'(rd_addr), 'h102);
        inc(3, 5);
        after_edge();
        cmp("inc_illegal_err", int'(err), 1);
        rd(3, 7);
        after_edge();
        cmp("rd_illegal_err", int'(err), 1);
        cmp("rd_illegal_addr", int'(rd_addr), 'h104);
        inc(7, 1);
        after_edge();
        cmp("unconfigured_err", int'(err), 1);
        inc(3, 1, 1, 3, 0);
        after_edge();
        cmp("collision_head", int'(rd_head), 4);
        rd(3, 0);
        after_edge();
        cmp("collision_next_head", int'(rd_head), 0);
        cyc(0, 1, 1, 0, 'h020, 8, 0, 0, 0, 0);
        cyc(0, 1, 1, 15, 'hFFF, 3, 0, 0, 0, 0);
        inc(0, 7); inc(15, 1); inc(0, 3); inc(15, 1, 1, 0, 0);
        rd(15, 0);
        after_edge();
        cmp("iso_ch15_head", int'(rd_head), 2);
        cmp("addr_wrap", int'(rd_addr), 'h001);
        rd(0, 5);
        cyc(0, 1, 3, 15, 0, 0, 0, 1, 15, 2);
        rd(15, 2);
        for (int n = 0; n < 3000; n++) begin
            int ch, rc;
            ch = $urandom_range(0, 3) == 0 ? $urandom_range(0, 15) : $urandom_range(0, 3);
            rc = $urandom_range(0, 1) == 0 ? ch : $urandom_range(0, 15);
            cyc($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 3), ch,
                $urandom_range(0, 4095), $urandom_range(0, 4) == 0 ? $urandom_range(0, 1023) : $urandom_range(0, 12),
                $urandom_range(0, 15), $urandom_range(0, 9) < 7, rc,
                $urandom_range(0, 9) == 0 ? $urandom_range(0, 1023) : $urandom_range(0, 14));
        end
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        if (q.size() != 0) cmp("queue_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
